// File: rtl/pipe_adder_pkg.sv
// Shared constants for the pipelined adder.
// Saturation limits are built per WIDTH.
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;
  localparam int MAX_WIDTH  = 256;

  function automatic logic [MAX_WIDTH-1:0] sat_max(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] sat_min(input int w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG-bit slice of the carry chain.
// Also exposes the carry into its MSB.
module adder_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  // slice add; carry into MSB recovered from the MSB sum bit
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  assign cmsb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep carry-chained add/sub with valid/ready.
// Option: PIPE_ADDER_SAT_EN adds sat_i (clamp on overflow).
module pipelined_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             sub_i,
  input  logic             carry_i,
`ifdef PIPE_ADDER_SAT_EN
  input  logic             sat_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] in_a [STAGES];
  logic [WIDTH-1:0] in_b [STAGES];
  logic [WIDTH-1:0] in_s [STAGES];
  logic             in_c [STAGES];
  logic             in_v [STAGES];
  logic [WIDTH-1:0] s_n  [STAGES];

  logic [SEG-1:0]   seg_sum [STAGES];
  logic             seg_co  [STAGES];
  logic             seg_cm  [STAGES];

  logic             stall;
  logic [WIDTH-1:0] fin_s;
  logic             fin_ovf;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
  logic sat_q  [STAGES];
  logic in_sat [STAGES];
`endif

  assign stall   = v_q[LAST] & ~ready_i;
  assign ready_o = ~stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] nxt;

    if (k == 0) begin : g_head
      assign in_a[k] = src1_i;
      assign in_b[k] = sub_i ? ~src2_i : src2_i;
      assign in_c[k] = sub_i | carry_i;
      assign in_s[k] = '0;
      assign in_v[k] = valid_i;
`ifdef PIPE_ADDER_SAT_EN
      assign in_sat[k] = sat_i;
`endif
    end else begin : g_body
      assign in_a[k] = a_q[k-1];
      assign in_b[k] = b_q[k-1];
      assign in_c[k] = c_q[k-1];
      assign in_s[k] = s_q[k-1];
      assign in_v[k] = v_q[k-1];
`ifdef PIPE_ADDER_SAT_EN
      assign in_sat[k] = sat_q[k-1];
`endif
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (in_a[k][k*SEG +: SEG]),
      .b    (in_b[k][k*SEG +: SEG]),
      .cin  (in_c[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .cmsb (seg_cm[k])
    );

    // merge this stage's slice into the forwarded lower sum bits
    always_comb begin
      nxt = in_s[k];
      nxt[k*SEG +: SEG] = seg_sum[k];
    end

    assign s_n[k] = nxt;
  end

  assign fin_ovf = seg_co[LAST] ^ seg_cm[LAST];

`ifdef PIPE_ADDER_SAT_EN
  assign fin_s = (in_sat[LAST] && fin_ovf)
               ? (s_n[LAST][WIDTH-1] ? SAT_MAX : SAT_MIN)
               : s_n[LAST];
`else
  assign fin_s = s_n[LAST];
`endif

  // advance every stage together unless the output is stalled
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= in_v[k];
        c_q[k] <= seg_co[k];
        a_q[k] <= in_a[k];
        b_q[k] <= in_b[k];
        s_q[k] <= (k == LAST) ? fin_s : s_n[k];
`ifdef PIPE_ADDER_SAT_EN
        sat_q[k] <= in_sat[k];
`endif
      end
      ovf_q <= fin_ovf;
    end
  end

  assign valid_o = v_q[LAST];
  assign sum_o   = valid_o ? s_q[LAST] : '0;
  assign carry_o = valid_o & c_q[LAST];
  assign ovf_o   = valid_o & ovf_q;

  logic unused_bits;
`ifdef PIPE_ADDER_SAT_EN
  assign unused_bits = ^{a_q[LAST], b_q[LAST], sat_q[LAST]};
`else
  assign unused_bits = ^{a_q[LAST], b_q[LAST]};
`endif

endmodule
